// File: rtl/turnstile_pkg.sv
// Shared state encodings for the turnstile gate controller.
package turnstile_pkg;

  localparam int unsigned StateW = 2;

  typedef enum logic [StateW-1:0] {
    StLocked   = 2'b00,
    StUnlocked = 2'b01,
    StPassing  = 2'b10,
    StAlarm    = 2'b11
  } state_e;

endpackage

// File: rtl/tick_timer.sv
// Loadable down-counter with zero flag; holds at zero once reached.
module tick_timer #(
  parameter int unsigned Width = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] load_val_i,
  input  logic             load_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/turnstile_gate_ctrl.sv
// Turnstile lock controller: grant-driven unlock window, single-passage admission,
// forced-push alarm and saturating passage counter.
module turnstile_gate_ctrl
  import turnstile_pkg::*;
#(
  parameter int unsigned UNLOCK_CYCLES = 20,
  parameter int unsigned ALARM_CYCLES  = 8,
  parameter int unsigned CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              open_access_door,
  input  logic              pass_sensor,
  input  logic              push_attempt,
  output logic              gate_unlock,
  output logic              alarm,
  output logic              timeout_pulse,
  output logic [CNT_W-1:0]  passage_count,
  output logic [StateW-1:0] state_out
);

  localparam int unsigned MaxCycles = (UNLOCK_CYCLES > ALARM_CYCLES) ? UNLOCK_CYCLES
                                                                      : ALARM_CYCLES;
  localparam int unsigned TimerW = $clog2(MaxCycles);
  localparam logic [TimerW-1:0] UnlockLoad = TimerW'(UNLOCK_CYCLES - 1);
  localparam logic [TimerW-1:0] AlarmLoad  = TimerW'(ALARM_CYCLES - 1);

  state_e            state_q, state_d;
  logic              open_q;
  logic              grant_edge;
  logic              gate_unlock_q, alarm_q, timeout_q, timeout_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              cnt_inc;
  logic              tmr_load, tmr_dec, tmr_zero;
  logic [TimerW-1:0] tmr_val;

  assign grant_edge = open_access_door & ~open_q;

  tick_timer #(
    .Width (TimerW)
  ) u_tick_timer (
    .clk        (clk),
    .rst        (rst),
    .load_val_i (tmr_val),
    .load_i     (tmr_load),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  // Timer only runs while a window or alarm is active; in PASSING it is unused.
  assign tmr_dec = (state_q == StUnlocked) || (state_q == StAlarm);

  always_comb begin
    state_d   = state_q;
    timeout_d = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    cnt_inc   = 1'b0;
    unique case (state_q)
      StLocked: begin
        if (grant_edge) begin
          state_d  = StUnlocked;
          tmr_load = 1'b1;
          tmr_val  = UnlockLoad;
        end else if (push_attempt) begin
          state_d  = StAlarm;
          tmr_load = 1'b1;
          tmr_val  = AlarmLoad;
        end
      end
      StUnlocked: begin
        if (pass_sensor) begin
          state_d = StPassing;
        end else if (tmr_zero) begin
          state_d   = StLocked;
          timeout_d = 1'b1;
        end
      end
      StPassing: begin
        if (!pass_sensor) begin
          state_d = StLocked;
          cnt_inc = 1'b1;
        end
      end
      StAlarm: begin
        if (tmr_zero) begin
          state_d = StLocked;
        end
      end
      default: state_d = StLocked;
    endcase
  end

  assign count_d = (cnt_inc && (count_q != '1)) ? count_q + CNT_W'(1) : count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StLocked;
      open_q        <= 1'b0;
      gate_unlock_q <= 1'b0;
      alarm_q       <= 1'b0;
      timeout_q     <= 1'b0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      open_q        <= open_access_door;
      gate_unlock_q <= (state_d == StUnlocked) || (state_d == StPassing);
      alarm_q       <= (state_d == StAlarm);
      timeout_q     <= timeout_d;
      count_q       <= count_d;
    end
  end

  assign gate_unlock   = gate_unlock_q;
  assign alarm         = alarm_q;
  assign timeout_pulse = timeout_q;
  assign passage_count = count_q;
  assign state_out     = state_q;

endmodule

// File: tb/tb_turnstile_gate_ctrl.sv
// Scoreboard bench for turnstile_gate_ctrl: default instance plus a CNT_W=2 instance
// sharing the same stimulus to exercise counter saturation.
module tb_turnstile_gate_ctrl;

  localparam int U = 20;
  localparam int A = 8;

  logic        clk = 1'b0;
  logic        rst, open_access_door, pass_sensor, push_attempt;
  logic        gate_unlock, alarm, timeout_pulse;
  logic [15:0] passage_count;
  logic [1:0]  state_out;
  logic        s_gate_unlock, s_alarm, s_timeout_pulse;
  logic [1:0]  s_passage_count;
  logic [1:0]  s_state_out;

  always #5 clk = ~clk;

  turnstile_gate_ctrl #(
    .UNLOCK_CYCLES (U),
    .ALARM_CYCLES  (A),
    .CNT_W         (16)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .open_access_door (open_access_door),
    .pass_sensor      (pass_sensor),
    .push_attempt     (push_attempt),
    .gate_unlock      (gate_unlock),
    .alarm            (alarm),
    .timeout_pulse    (timeout_pulse),
    .passage_count    (passage_count),
    .state_out        (state_out)
  );

  turnstile_gate_ctrl #(
    .UNLOCK_CYCLES (U),
    .ALARM_CYCLES  (A),
    .CNT_W         (2)
  ) dut_sat (
    .clk              (clk),
    .rst              (rst),
    .open_access_door (open_access_door),
    .pass_sensor      (pass_sensor),
    .push_attempt     (push_attempt),
    .gate_unlock      (s_gate_unlock),
    .alarm            (s_alarm),
    .timeout_pulse    (s_timeout_pulse),
    .passage_count    (s_passage_count),
    .state_out        (s_state_out)
  );

  typedef struct {
    int st;
    bit gate;
    bit alm;
    bit to;
    int cnt;
    int cnt2;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state
  int m_st, m_tmr, m_cnt, m_cnt2;
  bit m_open, m_to;

  // Tallies of observed outputs for window-length checks
  int gate_cnt, alarm_cnt, to_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_tallies();
    gate_cnt  = 0;
    alarm_cnt = 0;
    to_cnt    = 0;
  endtask

  task automatic step(input bit r, input bit o, input bit pa, input bit pu);
    exp_t e;
    bit   g_edge;
    rst              = r;
    open_access_door = o;
    pass_sensor      = pa;
    push_attempt     = pu;
    if (r) begin
      m_st = 0; m_tmr = 0; m_cnt = 0; m_cnt2 = 0; m_open = 0; m_to = 0;
    end else begin
      g_edge = o && !m_open;
      m_open = o;
      m_to   = 0;
      case (m_st)
        0: if (g_edge) begin m_st = 1; m_tmr = U - 1; end
           else if (pu) begin m_st = 3; m_tmr = A - 1; end
        1: if (pa) m_st = 2;
           else if (m_tmr == 0) begin m_st = 0; m_to = 1; end
           else m_tmr--;
        2: if (!pa) begin
             m_st = 0;
             if (m_cnt < 65535) m_cnt++;
             if (m_cnt2 < 3) m_cnt2++;
           end
        default: if (m_tmr == 0) m_st = 0; else m_tmr--;
      endcase
    end
    e.st   = m_st;
    e.gate = (m_st == 1) || (m_st == 2);
    e.alm  = (m_st == 3);
    e.to   = m_to;
    e.cnt  = m_cnt;
    e.cnt2 = m_cnt2;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("state",         32'(state_out),       32'(e.st));
    check("gate_unlock",   32'(gate_unlock),     32'(e.gate));
    check("alarm",         32'(alarm),           32'(e.alm));
    check("timeout_pulse", 32'(timeout_pulse),   32'(e.to));
    check("passage_count", 32'(passage_count),   32'(e.cnt));
    check("sat_state",     32'(s_state_out),     32'(e.st));
    check("sat_count",     32'(s_passage_count), 32'(e.cnt2));
    gate_cnt  += int'(gate_unlock);
    alarm_cnt += int'(alarm);
    to_cnt    += int'(timeout_pulse);
  endtask

  initial begin
    rst = 1'b1; open_access_door = 1'b0; pass_sensor = 1'b0; push_attempt = 1'b0;

    // Reset
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    // 1: grant with no passage times out after exactly U cycles
    clear_tallies();
    step(0, 1, 0, 0);
    repeat (24) step(0, 1, 0, 0);
    check("t1_gate_cycles", 32'(gate_cnt), 32'(U));
    check("t1_timeouts",    32'(to_cnt),   32'd1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // 2: normal passage
    clear_tallies();
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    repeat (3) step(0, 0, 1, 0);
    repeat (3) step(0, 0, 0, 0);
    check("t2_timeouts", 32'(to_cnt),        32'd0);
    check("t2_count",    32'(passage_count), 32'd1);

    // 3: forced push alarm, grant during alarm ignored
    clear_tallies();
    step(0, 0, 0, 1);
    repeat (2) step(0, 0, 0, 0);
    step(0, 1, 0, 1);
    repeat (8) step(0, 0, 0, 0);
    check("t3_alarm_cycles", 32'(alarm_cnt), 32'(A));
    check("t3_gate_cycles",  32'(gate_cnt),  32'd0);

    // 4: grant+push together, then pass on the last unlock cycle
    clear_tallies();
    step(0, 1, 0, 1);
    check("t4_no_alarm", 32'(alarm), 32'd0);
    repeat (19) step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    check("t4_passing", 32'(state_out), 32'd2);
    repeat (2) step(0, 0, 0, 0);
    check("t4_timeouts", 32'(to_cnt), 32'd0);

    // 5: two grants in one window admit one passage; next push raises alarm
    clear_tallies();
    step(0, 1, 0, 0);
    repeat (2) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    repeat (2) step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 1);
    step(0, 0, 1, 0);
    repeat (8) step(0, 0, 0, 0);
    check("t5_count",        32'(passage_count), 32'd3);
    check("t5_alarm_cycles", 32'(alarm_cnt),     32'(A));

    // 6: reset mid-passage, then saturation of the narrow counter
    step(0, 1, 0, 0);
    repeat (2) step(0, 0, 1, 0);
    step(1, 0, 1, 0);
    check("t6_rst_state", 32'(state_out),     32'd0);
    check("t6_rst_gate",  32'(gate_unlock),   32'd0);
    check("t6_rst_count", 32'(passage_count), 32'd0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 0);
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
    end
    check("t6_count",     32'(passage_count),   32'd5);
    check("t6_sat_count", 32'(s_passage_count), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
